// File: rtl/rle_codec.sv
// Run-length compressor/decompressor, a bus master on DPSRAM port A.
// Word-only reads and writes; pairs are (symbol, count) bytes packed little-endian.
module rle_codec #(
   parameter int ADDR_W  = 16,
   parameter int MAX_RUN = 255
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              start,
   input  logic              mode,
   input  logic [31:0]       message_addr,
   input  logic [31:0]       message_size,
   input  logic [31:0]       rle_addr,
   output logic [31:0]       rle_size,
   output logic              done,
   output logic              error,
   output logic              port_A_clk,
   output logic [ADDR_W-1:0] port_A_addr,
   output logic [31:0]       port_A_data_in,
   input  logic [31:0]       port_A_data_out,
   output logic              port_A_we
);

   localparam logic [7:0] MAX_CNT = 8'(MAX_RUN);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_PROC, S_WR, S_FLUSH, S_DONE
   } state_t;

   state_t      state_q, n_state;
   logic        mode_q, n_mode;
   logic [31:0] src_base, n_src_base;
   logic [31:0] dst_addr, n_dst_addr;
   logic [31:0] size_q, n_size;
   logic [31:0] src_idx, n_idx;
   logic [31:0] out_buf, n_buf;
   logic [2:0]  buf_cnt, n_cnt;
   logic [7:0]  sym_q, n_sym;
   logic [7:0]  run_q, n_run;
   logic        have_run, n_have;
   logic        word_valid, n_wv;
   logic        fresh, n_fresh;
   logic [31:0] src_word, n_src_word;
   logic [31:0] rle_cnt, n_rle;
   logic        err_q, n_err;

   logic [31:0] cur_word, sh0, sh1;
   logic [7:0]  byte0, byte1;
   logic [4:0]  ins_sh;
   logic        do_route, src_need, fin;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q    <= S_IDLE;
         mode_q     <= 1'b0;
         src_base   <= '0;
         dst_addr   <= '0;
         size_q     <= '0;
         src_idx    <= '0;
         out_buf    <= '0;
         buf_cnt    <= '0;
         sym_q      <= '0;
         run_q      <= '0;
         have_run   <= 1'b0;
         word_valid <= 1'b0;
         fresh      <= 1'b0;
         src_word   <= '0;
         rle_cnt    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= n_state;
         mode_q     <= n_mode;
         src_base   <= n_src_base;
         dst_addr   <= n_dst_addr;
         size_q     <= n_size;
         src_idx    <= n_idx;
         out_buf    <= n_buf;
         buf_cnt    <= n_cnt;
         sym_q      <= n_sym;
         run_q      <= n_run;
         have_run   <= n_have;
         word_valid <= n_wv;
         fresh      <= n_fresh;
         src_word   <= n_src_word;
         rle_cnt    <= n_rle;
         err_q      <= n_err;
      end
   end

   always_comb begin
      n_state    = state_q;
      n_mode     = mode_q;
      n_src_base = src_base;
      n_dst_addr = dst_addr;
      n_size     = size_q;
      n_idx      = src_idx;
      n_buf      = out_buf;
      n_cnt      = buf_cnt;
      n_sym      = sym_q;
      n_run      = run_q;
      n_have     = have_run;
      n_wv       = word_valid;
      n_fresh    = fresh;
      n_src_word = src_word;
      n_rle      = rle_cnt;
      n_err      = err_q;
      do_route   = 1'b0;
      src_need   = 1'b0;
      fin        = 1'b0;

      // The fetched word is only on the bus in the first PROC cycle; later cycles use the copy.
      cur_word = fresh ? port_A_data_out : src_word;
      sh0      = cur_word >> {src_idx[1:0], 3'b000};
      sh1      = cur_word >> {src_idx[1:0] + 2'd1, 3'b000};
      byte0    = sh0[7:0];
      byte1    = sh1[7:0];
      ins_sh   = {buf_cnt[1:0], 3'b000};

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               n_mode     = mode;
               n_src_base = message_addr;
               n_dst_addr = rle_addr;
               n_size     = message_size;
               n_idx      = '0;
               n_buf      = '0;
               n_cnt      = '0;
               n_have     = 1'b0;
               n_run      = '0;
               n_wv       = 1'b0;
               n_fresh    = 1'b0;
               n_rle      = '0;
               n_err      = 1'b0;
               if (message_size == '0) begin
                  n_state = S_DONE;
               end else if (mode && message_size[0]) begin
                  n_err   = 1'b1;
                  n_state = S_DONE;
               end else begin
                  n_state = S_RD_REQ;
               end
            end
         end
         S_RD_REQ:  n_state = S_RD_WAIT;
         S_RD_WAIT: begin
            n_state = S_PROC;
            n_fresh = 1'b1;
            n_wv    = 1'b1;
         end
         S_PROC: begin
            n_fresh = 1'b0;
            if (fresh) n_src_word = port_A_data_out;
            do_route = 1'b1;
            if (!mode_q) begin
               // Pairs land at even buffer offsets only, so a pair always fits.
               if (src_idx == size_q) begin
                  n_buf  = out_buf | ({16'h0, run_q, sym_q} << ins_sh);
                  n_cnt  = buf_cnt + 3'd2;
                  n_rle  = rle_cnt + 32'd2;
                  n_have = 1'b0;
               end else begin
                  n_idx = src_idx + 32'd1;
                  if (src_idx[1:0] == 2'b11) n_wv = 1'b0;
                  if (have_run && byte0 == sym_q && run_q < MAX_CNT) begin
                     n_run = run_q + 8'd1;
                  end else begin
                     if (have_run) begin
                        n_buf = out_buf | ({16'h0, run_q, sym_q} << ins_sh);
                        n_cnt = buf_cnt + 3'd2;
                        n_rle = rle_cnt + 32'd2;
                     end
                     n_sym  = byte0;
                     n_run  = 8'd1;
                     n_have = 1'b1;
                  end
               end
            end else begin
               if (run_q != '0) begin
                  n_buf = out_buf | ({24'h0, sym_q} << ins_sh);
                  n_cnt = buf_cnt + 3'd1;
                  n_rle = rle_cnt + 32'd1;
                  n_run = run_q - 8'd1;
               end else if (byte1 == '0) begin
                  n_err = 1'b1;
               end else begin
                  n_sym = byte0;
                  n_run = byte1 - 8'd1;
                  n_buf = out_buf | ({24'h0, byte0} << ins_sh);
                  n_cnt = buf_cnt + 3'd1;
                  n_rle = rle_cnt + 32'd1;
                  n_idx = src_idx + 32'd2;
                  if (src_idx[1]) n_wv = 1'b0;
               end
            end
         end
         S_WR: begin
            n_buf      = '0;
            n_cnt      = '0;
            n_dst_addr = dst_addr + 32'd4;
            do_route   = 1'b1;
         end
         S_FLUSH: begin
            n_buf   = '0;
            n_cnt   = '0;
            n_state = S_DONE;
         end
         default: n_state = S_IDLE;
      endcase

      if (do_route) begin
         src_need = mode_q ? (n_run == '0 && n_idx != size_q) : (n_idx != size_q);
         fin      = mode_q ? (n_err || (n_idx == size_q && n_run == '0))
                           : (n_idx == size_q && !n_have);
         if (n_cnt == 3'd4)           n_state = S_WR;
         else if (fin)                n_state = (n_cnt != '0) ? S_FLUSH : S_DONE;
         else if (src_need && !n_wv)  n_state = S_RD_REQ;
         else                         n_state = S_PROC;
      end
   end

   logic [31:0] rd_addr, addr_full;
   logic        wr_phase, unused_ok;

   always_comb begin
      rd_addr  = src_base + {src_idx[31:2], 2'b00};
      wr_phase = (state_q == S_WR) || (state_q == S_FLUSH);
      if (wr_phase)
         addr_full = dst_addr;
      else if (state_q == S_RD_REQ || state_q == S_RD_WAIT || state_q == S_PROC)
         addr_full = rd_addr;
      else
         addr_full = '0;
   end

   assign unused_ok      = ^addr_full;
   assign port_A_clk     = clk;
   // Gated by nreset so a reset landing on a write cycle never reaches memory.
   assign port_A_we      = nreset && wr_phase;
   assign port_A_addr    = {addr_full[ADDR_W-1:2], 2'b00};
   assign port_A_data_in = wr_phase ? out_buf : '0;
   assign done           = (state_q == S_DONE);
   assign error          = err_q;
   assign rle_size       = rle_cnt;

endmodule

// File: tb/tb_rle_codec.sv
// Directed bench for rle_codec: two instances (MAX_RUN 255 and 15) sharing one word memory.
// A byte-level model predicts every write and the final size/error of each job.
module tb_rle_codec;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        nreset;
   logic        start [2];
   logic        mode;
   logic [31:0] message_addr, message_size, rle_addr;
   logic [31:0] rle_size [2];
   logic        done [2], error [2], a_clk [2], a_we [2];
   logic [15:0] a_addr [2];
   logic [31:0] a_din [2], a_dout [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      rle_codec #(.ADDR_W(16), .MAX_RUN(g == 0 ? 255 : 15)) u_dut (
         .clk(clk), .nreset(nreset), .start(start[g]), .mode(mode),
         .message_addr(message_addr), .message_size(message_size), .rle_addr(rle_addr),
         .rle_size(rle_size[g]), .done(done[g]), .error(error[g]),
         .port_A_clk(a_clk[g]), .port_A_addr(a_addr[g]), .port_A_data_in(a_din[g]),
         .port_A_data_out(a_dout[g]), .port_A_we(a_we[g])
      );
   end

   logic [31:0] mem [16384];
   logic        ld_we;
   logic [13:0] ld_idx;
   logic [31:0] ld_data;
   int          cur;
   bit          no_write;

   always @(posedge clk) begin
      if (ld_we) mem[ld_idx] <= ld_data;
      else if (a_we[cur]) mem[a_addr[cur][15:2]] <= a_din[cur];
      a_dout[0] <= mem[a_addr[0][15:2]];
      a_dout[1] <= mem[a_addr[1][15:2]];
   end

   int          total = 0, bad = 0;
   logic [7:0]  src_q [$];
   logic [7:0]  out_q [$];
   bit          exp_err;
   logic [31:0] exp_wa [$];
   logic [31:0] exp_wd [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (a_we[i]) begin
            if (i != cur || no_write || exp_wa.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_write: inst %0d addr 0x%04h data 0x%08h, no write expected",
                        i, a_addr[i], a_din[i]);
            end else begin
               chk("wr_addr", {16'h0, a_addr[i]}, exp_wa.pop_front());
               chk("wr_data", a_din[i], exp_wd.pop_front());
            end
         end
      end
   end

   // Expected output byte stream straight from the format rules.
   task automatic model(input bit md, input int maxr, input int size);
      logic [7:0] s;
      int         c;
      bit         have;
      out_q.delete();
      exp_err = 1'b0;
      if (!md) begin
         have = 1'b0; s = '0; c = 0;
         for (int i = 0; i < size; i++) begin
            if (have && src_q[i] == s && c < maxr) c++;
            else begin
               if (have) begin out_q.push_back(s); out_q.push_back(8'(c)); end
               s = src_q[i]; c = 1; have = 1'b1;
            end
         end
         if (have) begin out_q.push_back(s); out_q.push_back(8'(c)); end
      end else if (size % 2 != 0) begin
         exp_err = 1'b1;
      end else begin
         for (int i = 0; i < size; i += 2) begin
            if (src_q[i+1] == 8'd0) begin exp_err = 1'b1; break; end
            for (int k = 0; k < int'(src_q[i+1]); k++) out_q.push_back(src_q[i]);
         end
      end
   endtask

   task automatic load_src(input logic [31:0] maddr, input logic [7:0] fill);
      int nw;
      logic [31:0] w;
      logic [7:0]  b;
      nw = (src_q.size() + 3) / 4;
      for (int i = 0; i < nw; i++) begin
         w = '0;
         for (int k = 0; k < 4; k++) begin
            b = (4*i + k < src_q.size()) ? src_q[4*i + k] : fill;
            w = w | (32'(b) << (8*k));
         end
         ld_we = 1'b1; ld_idx = 14'((maddr >> 2) + 32'(i)); ld_data = w;
         @(posedge clk); #1;
      end
      ld_we = 1'b0;
   endtask

   task automatic arm(input logic [31:0] raddr);
      logic [31:0] w;
      exp_wa.delete(); exp_wd.delete();
      for (int i = 0; i < out_q.size(); i += 4) begin
         w = '0;
         for (int k = 0; k < 4; k++)
            if (i + k < out_q.size()) w = w | (32'(out_q[i+k]) << (8*k));
         exp_wa.push_back(raddr + 32'(i)); exp_wd.push_back(w);
      end
   endtask

   task automatic run_job(input int inst, input bit md, input logic [31:0] maddr, input int size,
                          input logic [31:0] raddr, input bit chk_bound, input bit poke,
                          output int edges);
      int k, n, nb;
      logic [7:0] fill;
      fill = (md || src_q.size() == 0) ? 8'h00 : src_q[src_q.size()-1];
      load_src(maddr, fill);
      model(md, inst == 0 ? 255 : 15, size);
      arm(raddr);
      cur = inst;
      mode = md; message_addr = maddr; message_size = 32'(size); rle_addr = raddr;
      start[inst] = 1'b1;
      @(posedge clk); #1;
      start[inst] = 1'b0;
      k = 0;
      while (!done[inst] && k < 3000) begin
         if (poke) begin start[inst] = (k == 3); mode = (k == 3) ? ~md : md; end
         @(posedge clk); #1;
         k++;
      end
      start[inst] = 1'b0; mode = md;
      edges = k + 1;
      if (!done[inst]) begin
         total++; bad++;
         $display("FAIL done_timeout: done still 0 after %0d cycles, expected 1", edges);
      end
      chk("done", {31'b0, done[inst]}, 32'd1);
      chk("rle_size", rle_size[inst], 32'(out_q.size()));
      chk("error", {31'b0, error[inst]}, {31'b0, exp_err});
      chk("writes_left", 32'(exp_wa.size()), 32'd0);
      if (chk_bound) begin
         n  = md ? out_q.size() : size;
         nb = 2*((n + 3)/4) + n + (out_q.size() + 3)/4 + 3;
         total++;
         if (edges > nb) begin
            bad++;
            $display("FAIL latency: got %0d cycles expected <= %0d", edges, nb);
         end
      end
      exp_wa.delete(); exp_wd.delete();
   endtask

   int cyc;

   initial begin
      nreset = 1'b0; start[0] = 1'b0; start[1] = 1'b0; mode = 1'b0;
      message_addr = '0; message_size = '0; rle_addr = '0;
      ld_we = 1'b0; ld_idx = '0; ld_data = '0; cur = 0; no_write = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_done", {31'b0, done[i]}, 32'd0);
         chk("rst_error", {31'b0, error[i]}, 32'd0);
         chk("rst_size", rle_size[i], 32'd0);
         chk("rst_we", {31'b0, a_we[i]}, 32'd0);
         chk("rst_addr", {16'h0, a_addr[i]}, 32'd0);
      end
      nreset = 1'b1;
      @(posedge clk); #1;

      // 48 x 0x41, one run
      src_q.delete(); repeat (48) src_q.push_back(8'h41);
      run_job(0, 1'b0, 32'h0, 48, 32'hC8, 1'b1, 1'b0, cyc);
      chk("t1_word", mem[32'hC8 >> 2], 32'h0000_3041);
      chk("t1_size", rle_size[0], 32'd2);

      // same input, MAX_RUN = 15
      run_job(1, 1'b0, 32'h0, 48, 32'h100, 1'b1, 1'b0, cyc);
      chk("t2_w0", mem[32'h100 >> 2], 32'h0F41_0F41);
      chk("t2_w1", mem[(32'h100 >> 2) + 1], 32'h0341_0F41);
      chk("t2_size", rle_size[1], 32'd8);

      // 51 distinct bytes; final source byte slot repeats 0x32 and must be ignored
      src_q.delete(); for (int i = 0; i < 51; i++) src_q.push_back(8'(i));
      run_job(0, 1'b0, 32'h400, 51, 32'h800, 1'b1, 1'b1, cyc);
      chk("t3_last", mem[(32'h800 >> 2) + 25], 32'h0000_0132);
      chk("t3_size", rle_size[0], 32'd102);

      // decompress (41,05)
      src_q = {8'h41, 8'h05};
      run_job(0, 1'b1, 32'h12C, 2, 32'hA00, 1'b1, 1'b0, cyc);
      chk("t4_w0", mem[32'hA00 >> 2], 32'h4141_4141);
      chk("t4_w1", mem[(32'hA00 >> 2) + 1], 32'h0000_0041);

      // round trip of the first job's output
      src_q = {8'h41, 8'h30};
      run_job(0, 1'b1, 32'hC8, 2, 32'hC00, 1'b1, 1'b0, cyc);
      for (int i = 0; i < 12; i++) chk("t5_word", mem[(32'hC00 >> 2) + i], 32'h4141_4141);
      chk("t5_size", rle_size[0], 32'd48);

      // count 0 in the first pair
      src_q = {8'h42, 8'h00, 8'h02, 8'h00};
      run_job(0, 1'b1, 32'h1000, 4, 32'h1100, 1'b0, 1'b0, cyc);
      chk("t6_err", {31'b0, error[0]}, 32'd1);
      chk("t6_size", rle_size[0], 32'd0);

      // odd size
      src_q = {8'h41, 8'h02, 8'h43};
      run_job(0, 1'b1, 32'h1000, 3, 32'h1100, 1'b0, 1'b0, cyc);
      chk("t7_err", {31'b0, error[0]}, 32'd1);

      // fault after some output
      src_q = {8'h41, 8'h03, 8'h42, 8'h00};
      run_job(0, 1'b1, 32'h1000, 4, 32'h1200, 1'b0, 1'b0, cyc);
      chk("t8_word", mem[32'h1200 >> 2], 32'h0041_4141);
      chk("t8_size", rle_size[0], 32'd3);

      // mixed runs split at 15
      src_q.delete();
      repeat (20) src_q.push_back(8'h07);
      src_q.push_back(8'h08);
      repeat (17) src_q.push_back(8'h09);
      run_job(1, 1'b0, 32'h1400, 38, 32'h1500, 1'b1, 1'b0, cyc);
      chk("t9_size", rle_size[1], 32'd10);
      chk("t9_last", mem[(32'h1500 >> 2) + 2], 32'h0000_0209);

      // reset in the middle of a compress job
      src_q.delete(); for (int i = 0; i < 51; i++) src_q.push_back(8'(i));
      load_src(32'h400, 8'h32);
      model(1'b0, 255, 51);
      arm(32'h1800);
      cur = 0; mode = 1'b0; message_addr = 32'h400; message_size = 32'd51; rle_addr = 32'h1800;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (40) begin @(posedge clk); #1; end
      nreset = 1'b0; no_write = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_done", {31'b0, done[0]}, 32'd0);
      chk("mid_rst_error", {31'b0, error[0]}, 32'd0);
      chk("mid_rst_size", rle_size[0], 32'd0);
      chk("mid_rst_we", {31'b0, a_we[0]}, 32'd0);
      chk("mid_rst_addr", {16'h0, a_addr[0]}, 32'd0);
      chk("mid_rst_din", a_din[0], 32'd0);
      chk("port_clk", {31'b0, a_clk[0]}, {31'b0, clk});
      nreset = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      chk("mid_rst_idle", {31'b0, done[0]}, 32'd0);
      no_write = 1'b0;
      exp_wa.delete(); exp_wd.delete();

      // empty message
      src_q.delete();
      run_job(0, 1'b0, 32'h2000, 0, 32'h2100, 1'b0, 1'b0, cyc);
      total++;
      if (cyc > 2) begin
         bad++;
         $display("FAIL empty_latency: got %0d cycles expected <= 2", cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rle_codec.md
# rle_codec

Parametrised run-length compressor/decompressor, the next generation of the team's single-mode RLE processor. It shares the same word-only DPSRAM port A protocol, so it drops into the existing memory subsystem. It adds a decompress mode, a configurable maximum run length and a configurable address width, plus error reporting for malformed compressed streams. The block is a bus master on port A. Its host side takes a start, addresses and a size, and returns done and an output byte count.

## Interface
- ADDR_W, 16, width of port_A_addr; byte address, word-aligned accesses only
- MAX_RUN, 255, largest count emitted in one pair; legal range 1..255
- clk  in  1  sole clock; all logic on rising edge
- nreset  in  1  synchronous, active-low reset
- start  in  1  sampled in IDLE only; starts a job
- mode  in  1  0 = compress, 1 = decompress; sampled with start
- message_addr  in  32  byte address of source; must be multiple of 4
- message_size  in  32  source length in bytes
- rle_addr  in  32  byte address of destination; must be multiple of 4
- rle_size  out  32  bytes written to destination; valid while done=1
- done  out  1  high from job end until the next accepted start
- error  out  1  decompress stream fault; valid while done=1
- port_A_clk  out  1  equals clk
- port_A_addr  out  ADDR_W  word-aligned byte address (low 2 bits always 0)
- port_A_data_in  out  32  write data
- port_A_data_out  in  32  read data
- port_A_we  out  1  1 = write, 0 = read

## Operation
- Byte packing is little-endian. The byte at offset a lives in word a>>2, bits [8*(a%4)+7 : 8*(a%4)].
- Compressed format is a sequence of pairs: symbol byte, then count byte. Count is 1..MAX_RUN.
- Compress:
  - Scans source bytes in order and extends the current run while the byte equals the symbol and count < MAX_RUN.
  - Otherwise it emits the pair and starts a new run.
  - The final run is emitted at end of input.
- Decompress:
  - Reads pairs and writes the symbol count times.
  - A count of 0, or an odd message_size, sets error and ends the job. Bytes already written remain; rle_size reports them.
- Output bytes are gathered into a 4-byte word buffer. The buffer is written when full.
- At end of job, a partial last word is written with its unused upper bytes = 0x00. rle_size excludes those pad bytes.
- Source bytes beyond message_size in the last word are ignored.
- States: IDLE → RD_REQ → RD_WAIT → PROC → (WR when buffer full) → back to PROC or RD_REQ → FLUSH → DONE.
  - PROC consumes 1 byte per cycle (compress) or emits 1 byte per cycle (decompress).
- message_size = 0: IDLE → DONE directly, no memory access, rle_size = 0, error = 0.
- start while not IDLE/DONE is ignored. start in DONE clears done and begins a new job.
- Arithmetic: rle_size is a 32-bit counter. Run count is 8 bits and saturates at MAX_RUN by emitting, never by wrapping.

## Timing
- Reset (nreset=0 at a rising edge): state IDLE, done=0, error=0, rle_size=0, port_A_we=0, port_A_addr=0, port_A_data_in=0.
- Reset mid-job aborts immediately. There is no write on the reset cycle or after it.
- Read: address is driven with we=0 in cycle t. Memory registers data at edge t+1. The block uses port_A_data_out in cycle t+2. Each source word costs 2 cycles of fetch.
- Write: address, data and we=1 are driven in one cycle. we is high exactly 1 cycle per word.
- port_A_we is never high outside WR/FLUSH. Every address satisfies addr%4 == 0.
- done rises the cycle after the FLUSH write, or after the last WR if there is no partial word. rle_size is stable in that same cycle.
- Latency bound, compress: ≤ 2·ceil(N/4) + N + ceil(out/4) + 3 cycles from start to done.
- Decompress follows the same bound with N replaced by total expanded bytes.

## Test plan
- Compress 48 × 0x41, MAX_RUN=255, message_addr=0, rle_addr=0xC8 → one write 0x00003041 at 0xC8, rle_size=2, error=0.
- Same input with MAX_RUN=15 → pairs (41,0F)×3 then (41,03). Words 0x0F410F41 and 0x03410F41. rle_size=8.
- Compress 51 distinct bytes 0x00..0x32 → rle_size=102. The last word holds pair (32,01) with pad 0x0000. The MSB of the final source word is not read as data.
- Decompress 0x00000541 (size 2) at 0x12C → writes 0x41414141 then 0x00000041, rle_size=5. Round-trip of the first test returns the original 12 words exactly.
- Decompress with size 4, word 0x00020042 → 0x42 × 2 is not produced. The first pair has count 0, so error=1, rle_size=0, done=1. Odd size 3 → error=1.
- message_size=0 → done within 2 cycles, no port_A_we pulse. nreset low mid-job → no further writes, and all outputs return to reset values the next cycle.
